// File: rtl/imm_pack.sv
// rtl/imm_pack.sv - RV32I instruction-word builder: packs immediates into U/I/S/B/J slots and expands load-immediate
// into a LUI/ADDI pair behind a registered valid/ready output stage.
module imm_pack (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_li,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic        out_last
);

    typedef enum logic {IDLE, SECOND} state_t;

    state_t      state_q;
    logic        out_valid_q;
    logic [31:0] out_inst_q;
    logic        out_err_q;
    logic        out_last_q;
    logic [31:0] pend_q;

    logic [31:0] pack_inst;
    logic        pack_err;
    logic [19:0] li_hi;
    logic [31:0] word_d;
    logic        err_d;
    logic        last_d;
    logic        two_d;

    always_comb begin
        pack_inst = {25'b0, in_opcode};
        pack_err  = 1'b1;
        case (in_opcode[6:2])
            5'b01101, 5'b00101: begin
                pack_inst = {in_imm[31:12], in_rd, in_opcode};
                pack_err  = |in_imm[11:0];
            end
            5'b00000, 5'b00100, 5'b11001: begin
                pack_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                pack_err  = in_imm[31:11] != {21{in_imm[11]}};
            end
            5'b01000: begin
                pack_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                pack_err  = in_imm[31:11] != {21{in_imm[11]}};
            end
            5'b11000: begin
                pack_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], in_opcode};
                pack_err  = (in_imm[31:12] != {20{in_imm[12]}}) || in_imm[0];
            end
            5'b11011: begin
                pack_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                pack_err  = (in_imm[31:20] != {12{in_imm[20]}}) || in_imm[0];
            end
            5'b01100: begin
                pack_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                pack_err  = 1'b0;
            end
            default: ;
        endcase
    end

    // ADDI sign-extends its 12 bits, so the LUI half absorbs the borrow via imm[11].
    assign li_hi = in_imm[31:12] + {19'b0, in_imm[11]};

    always_comb begin
        word_d = pack_inst;
        err_d  = pack_err;
        last_d = 1'b1;
        two_d  = 1'b0;
        if (in_li) begin
            err_d = 1'b0;
            if (in_rd == 5'd0) begin
                word_d = 32'h0000_0013;
            end else if (li_hi == 20'd0) begin
                word_d = {in_imm[11:0], 5'd0, 3'b000, in_rd, 7'h13};
            end else if (in_imm[11:0] == 12'd0) begin
                word_d = {li_hi, in_rd, 7'h37};
            end else begin
                word_d = {li_hi, in_rd, 7'h37};
                last_d = 1'b0;
                two_d  = 1'b1;
            end
        end
    end

    assign in_ready  = !rst && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_err   = out_err_q;
    assign out_last  = out_last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_inst_q  <= 32'd0;
            out_err_q   <= 1'b0;
            out_last_q  <= 1'b0;
            pend_q      <= 32'd0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        out_valid_q <= 1'b1;
                        out_inst_q  <= word_d;
                        out_err_q   <= err_d;
                        out_last_q  <= last_d;
                        if (two_d) begin
                            pend_q  <= {in_imm[11:0], in_rd, 3'b000, in_rd, 7'h13};
                            state_q <= SECOND;
                        end
                    end
                end
                SECOND: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b1;
                        out_inst_q  <= pend_q;
                        out_err_q   <= 1'b0;
                        out_last_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_pack.sv
// tb/tb_imm_pack.sv - randomized and directed bench for imm_pack against a word-level reference model.
module tb_imm_pack;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
        logic        last;
    } exp_t;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
        logic        last;
        logic [31:0] cyc;
    } log_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_li = 1'b0;
    logic [6:0]  in_opcode = 7'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [4:0]  in_rs1 = 5'd0;
    logic [4:0]  in_rs2 = 5'd0;
    logic [2:0]  in_funct3 = 3'd0;
    logic [6:0]  in_funct7 = 7'd0;
    logic [31:0] in_imm = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic        out_err;
    logic        out_last;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    bit          chk_en = 1'b0;
    int          ready_mode = 0;
    logic [31:0] cyc = 32'd0;
    exp_t        q[$];
    log_t        log_q[$];

    imm_pack dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_li(in_li),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_err(out_err), .out_last(out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 32'd1;
        #2;
        out_ready = (ready_mode == 1) ? 1'b1 :
                    (ready_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic void model_req(input logic li, input logic [6:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [31:0] imm);
        logic [31:0] w, base, hi, d;
        int          si, lo;
        logic        e;
        si   = $signed(imm);
        base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
        if (li) begin
            lo = imm[11] ? int'(imm[11:0]) - 4096 : int'(imm[11:0]);
            d  = imm - 32'(lo);
            hi = d >> 12;
            if (rd == 5'd0) begin
                q.push_back('{32'h13, 1'b0, 1'b1});
            end else if (hi == 32'd0) begin
                q.push_back('{((imm & 32'hFFF) << 20) | (32'(rd) << 7) | 32'h13, 1'b0, 1'b1});
            end else if (lo == 0) begin
                q.push_back('{(hi << 12) | (32'(rd) << 7) | 32'h37, 1'b0, 1'b1});
            end else begin
                q.push_back('{(hi << 12) | (32'(rd) << 7) | 32'h37, 1'b0, 1'b0});
                q.push_back('{((imm & 32'hFFF) << 20) | (32'(rd) << 15) | (32'(rd) << 7) | 32'h13,
                              1'b0, 1'b1});
            end
            return;
        end
        case (op[6:2])
            5'b01101, 5'b00101: begin
                w = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(op);
                e = (imm % 4096) != 0;
            end
            5'b00000, 5'b00100, 5'b11001: begin
                w = ((imm & 32'hFFF) << 20) | base | (32'(rd) << 7);
                e = si < -2048 || si > 2047;
            end
            5'b01000: begin
                w = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | base | ((imm & 32'h1F) << 7);
                e = si < -2048 || si > 2047;
            end
            5'b11000: begin
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (32'(rs2) << 20) | base
                    | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7);
                e = si < -4096 || si > 4095 || (imm % 2) != 0;
            end
            5'b11011: begin
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 1) << 20)
                    | (((imm >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | 32'(op);
                e = si < -(1 << 20) || si >= (1 << 20) || (imm % 2) != 0;
            end
            5'b01100: begin
                w = (32'(f7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7);
                e = 1'b0;
            end
            default: begin
                w = 32'(op);
                e = 1'b1;
            end
        endcase
        q.push_back('{w, e, 1'b1});
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("in_ready", 32'(in_ready),
                32'(!rst && (q.size() == 0 || (q.size() == 1 && out_ready))));
            if (out_valid && q.size() > 0) begin
                chk("out_inst", out_inst, q[0].inst);
                chk("out_err", 32'(out_err), 32'(q[0].err));
                chk("out_last", 32'(out_last), 32'(q[0].last));
            end
            if (rst) begin
                q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    log_q.push_back('{out_inst, out_err, out_last, cyc});
                    if (q.size() > 0) void'(q.pop_front());
                end
                if (in_valid && in_ready)
                    model_req(in_li, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
            end
        end
    end

    task automatic scramble();
        in_li = 1'($urandom);
        in_opcode = 7'($urandom);
        in_rd = 5'($urandom);
        in_rs1 = 5'($urandom);
        in_rs2 = 5'($urandom);
        in_funct3 = 3'($urandom);
        in_funct7 = 7'($urandom);
        in_imm = $urandom();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            scramble();
        end
    endtask

    task automatic send(input logic li, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
        bit done = 1'b0;
        in_valid = 1'b1; in_li = li; in_opcode = op; in_rd = rd; in_rs1 = rs1;
        in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7; in_imm = imm;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        scramble();
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_log(input string name, input int idx, input logic [31:0] inst,
                           input logic err, input logic last);
        if (idx >= log_q.size()) begin
            chk({name, "_missing"}, 32'(log_q.size()), 32'(idx + 1));
        end else begin
            chk(name, log_q[idx].inst, inst);
            chk({name, "_err"}, 32'(log_q[idx].err), 32'(err));
            chk({name, "_last"}, 32'(log_q[idx].last), 32'(last));
        end
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] b[12];
        int          v;
        b = '{32'd0, 32'd2047, 32'hFFFF_F800, 32'd2048, 32'hFFFF_F7FF, 32'd4094,
              32'hFFFF_F000, 32'd4096, 32'h8000_0000, 32'h000F_FFFE, 32'hFFF0_0000, 32'h0010_0000};
        case ($urandom_range(0, 4))
            0: return $urandom();
            1: begin v = int'($urandom_range(0, 8191)) - 4096; return 32'(v); end
            2: begin v = int'($urandom_range(0, (1 << 22) - 1)) - (1 << 21); return 32'(v); end
            3: return $urandom() & 32'hFFFF_F000;
            default: return b[$urandom_range(0, 11)];
        endcase
    endfunction

    initial begin
        logic [6:0] ops[11];
        ops = '{7'h37, 7'h17, 7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h33, 7'h0F, 7'h73};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_inst", out_inst, 32'd0);
        chk("reset_out_err", 32'(out_err), 32'd0);
        chk("reset_out_last", 32'(out_last), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        ready_mode = 1;
        idle(2);

        log_q.delete();
        send(1'b0, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("addi_latency_valid", 32'(out_valid), 32'd1);
        chk("addi_latency_inst", out_inst, 32'hFFF3_0293);
        @(posedge clk);
        #1;
        send(1'b0, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
        send(1'b0, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
        send(1'b0, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 7'd0, 32'd2048);
        send(1'b1, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
        send(1'b1, 7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_07FF);
        send(1'b1, 7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h8000_0000);
        send(1'b1, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hDEAD_BEEF);
        idle(4);
        chk_log("addi_m1", 0, 32'hFFF3_0293, 1'b0, 1'b1);
        chk_log("beq_8", 1, 32'h0020_8463, 1'b0, 1'b1);
        chk("beq_3_err", 32'(log_q.size() > 2 && log_q[2].err), 32'd1);
        chk("addi_2048_err", 32'(log_q.size() > 3 && log_q[3].err), 32'd1);
        chk_log("li_lui", 4, 32'h1234_6537, 1'b0, 1'b0);
        chk_log("li_addi", 5, 32'hFFF5_0513, 1'b0, 1'b1);
        chk_log("li_7ff", 6, 32'h7FF0_0093, 1'b0, 1'b1);
        chk_log("li_8000", 7, 32'h8000_00B7, 1'b0, 1'b1);
        chk_log("li_x0", 8, 32'h0000_0013, 1'b0, 1'b1);

        ready_mode = 0;
        idle(1);
        log_q.delete();
        send(1'b1, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_inst", out_inst, 32'h1234_6537);
            @(posedge clk);
            #1;
        end
        ready_mode = 1;
        idle(4);
        chk_log("bp_lui", 0, 32'h1234_6537, 1'b0, 1'b0);
        chk_log("bp_addi", 1, 32'hFFF5_0513, 1'b0, 1'b1);
        if (log_q.size() > 1) chk("bp_addi_cycle", log_q[1].cyc, log_q[0].cyc + 32'd1);

        log_q.delete();
        for (int i = 0; i < 8; i++)
            send(1'b0, 7'h13, 5'(i + 1), 5'd3, 5'd0, 3'd0, 7'd0, 32'(i));
        idle(3);
        chk("stream_count", 32'(log_q.size()), 32'd8);
        for (int i = 1; i < 8 && i < log_q.size(); i++) begin
            chk("stream_rd_order", 32'(log_q[i].inst[11:7]), 32'(i + 1));
            chk("stream_cycle", log_q[i].cyc, log_q[0].cyc + 32'(i));
        end

        log_q.delete();
        send(1'b1, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5FFF);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_second_valid", 32'(out_valid), 32'd0);
        chk("rst_second_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        idle(3);
        chk("rst_second_words", 32'(log_q.size()), 32'd1);
        chk_log("rst_second_lui", 0, 32'h1234_6537, 1'b0, 1'b0);

        ready_mode = 2;
        for (int n = 0; n < 400; n++) begin
            send(1'($urandom_range(0, 3) == 0), ops[$urandom_range(0, 10)], 5'($urandom),
                 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), rand_imm());
            idle($urandom_range(0, 2));
        end
        ready_mode = 1;
        idle(6);
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule

// File: doc/imm_pack.md
# imm_pack

Instruction-word builder for the RV32I datapath: the inverse of the immediate extractor. It accepts a field-level instruction request (opcode, registers, funct bits, 32-bit sign-extended immediate) and packs the immediate into the U/I/S/B/J bit positions of a 32-bit instruction word. It also expands a load-immediate request into a LUI/ADDI sequence, and emits words through a registered valid/ready output stage. It sits between the self-test and trace-replay sequencers and the instruction-memory write port.

## Interface
Parameters: none.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  request accepted when in_valid && in_ready
- in_li  in  1  1 = load-immediate expansion of in_imm into in_rd; 0 = single-word pack
- in_opcode  in  7  full opcode; ignored when in_li=1
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3; in_funct7  in  7  function fields
- in_imm  in  32  immediate value, in the same form the extractor produces (U: already shifted, B/J: byte offset)
- out_valid  out  1  out_inst valid; held until out_ready
- out_ready  in  1  consumer accepts word
- out_inst  out  32  packed instruction
- out_err  out  1  immediate out of range or misaligned for the format; word still emitted
- out_last  out  1  final word of the current request

## Operation
- Format by in_opcode[6:2]: 01101/00101 U; 00000/00100/11001 I; 01000 S; 11000 B; 11011 J. Any other value: out_inst={25'b0,in_opcode}, out_err=1.
- Packing:
  - U: {imm[31:12],rd,opcode}.
  - I: {imm[11:0],rs1,funct3,rd,opcode}.
  - S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}.
  - B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}.
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
  - funct7 is placed in bits [31:25] only for opcode[6:2]=01100 (R-type; imm ignored, err=0).
- out_err=1 when:
  - I/S: imm is not the sign extension of imm[11:0].
  - B: imm is not 13-bit signed, or imm[0]=1.
  - J: imm is not 21-bit signed, or imm[0]=1.
  - U: imm[11:0]≠0.
- Round-trip property: when err=0, extracting the immediate from out_inst returns in_imm exactly.
- Load-immediate (in_li=1): lo=sext(imm[11:0]), hi=imm[31:12]+imm[11] (mod 2^20).
  - rd=0: one word 0x00000013 (NOP).
  - hi=0: one word ADDI rd,x0,lo.
  - lo=0: one word LUI rd,hi.
  - else: two words, LUI rd,hi then ADDI rd,rd,lo.
  - out_err=0 always.
- FSM states:
  - IDLE: accept. A two-word li goes to SECOND; everything else stays in IDLE.
  - SECOND: on the first word's output handshake, load the ADDI word and return to IDLE.

## Timing
- in_ready = !rst && state==IDLE && (!out_valid || out_ready), combinational.
- Latency: the first word appears on out_valid one cycle after acceptance.
- The second li word is loaded in the cycle the first word handshakes and is valid the next cycle. Back-to-back requests sustain 1 word/cycle.
- out_inst, out_err and out_last hold stable while out_valid && !out_ready.
- out_last=1 on single-word outputs and on the ADDI of a two-word li; 0 on its LUI.
- Reset values: out_valid=0, out_inst=0, out_err=0, out_last=0, state=IDLE. Reset during SECOND discards the pending word, and no further output appears.
- in_* fields are sampled only at acceptance; later changes have no effect on output.

## Test plan
- Pack ADDI x5,x6,-1 (opcode 0x13, imm 0xFFFFFFFF) -> out_inst 0xFFF30293, err 0, last 1, one cycle after accept.
- Pack BEQ x1,x2,+8 (opcode 0x63) -> 0x00208463. Same request with imm=3 -> err 1. ADDI imm=2048 -> err 1.
- li x10,0x12345FFF -> 0x12346537 (last 0), then 0xFFF50513 (last 1). li x1,0x7FF -> single 0x7FF00093. li x1,0x80000000 -> single 0x800000B7. li x0,any -> 0x00000013.
- Backpressure: li x10,0x12345FFF with out_ready=0 for 3 cycles -> LUI word held stable, in_ready=0, ADDI word appears only the cycle after the LUI handshake.
- Stream 8 single-word packs with out_ready=1 -> 8 words on 8 consecutive cycles, in order.
- Assert rst the cycle after the LUI handshake of a two-word li -> out_valid=0 next cycle, ADDI word never emitted, in_ready=1 once rst drops.
